// File: rtl/bcd_seg_scan_if.sv
// Upstream BCD bus plus multiplexed seven-segment display drive for bcd_seg_scan.
// master = the side producing BCD values (and observing the display), slave = the scanner.
interface bcd_seg_scan_if #(
   parameter int numberOfDigits = 6
);
   logic [numberOfDigits-1:0][3:0] BinaryDecimal;
   logic                           enaIn;
   logic [6:0]                     segments;
   logic [numberOfDigits-1:0]      digitSel;
   logic                           frameStart;

   modport master (
      output BinaryDecimal, enaIn,
      input  segments, digitSel, frameStart
   );

   modport slave (
      input  BinaryDecimal, enaIn,
      output segments, digitSel, frameStart
   );
endinterface

// File: rtl/bcd_seg_scan.sv
// Multiplexed BCD seven-segment scanner with frame-synchronous display update.
// Optional macro BCD_LZ_BLANK_EN blanks leading zeros above the most significant nonzero digit.
module bcd_seg_scan #(
   parameter int numberOfDigits = 6,
   parameter int refreshDivider = 50000
) (
   input  logic          clk,
   input  logic          rst,
   bcd_seg_scan_if.slave bus
);
   localparam int CW = $clog2(refreshDivider);
   localparam int IW = (numberOfDigits > 1) ? $clog2(numberOfDigits) : 1;
   localparam logic [CW-1:0]             count_last = CW'(refreshDivider - 1);
   localparam logic [IW-1:0]             index_last = IW'(numberOfDigits - 1);
   localparam logic [numberOfDigits-1:0] one_hot0   = numberOfDigits'(1);

   logic [CW-1:0]                  count;
   logic [IW-1:0]                  index;
   logic [numberOfDigits-1:0][3:0] pending;
   logic [numberOfDigits-1:0][3:0] display;
   logic                           pending_flag;
   logic                           wrap_q;
   logic                           tick;
   logic                           wrap;
   logic                           blank;
   logic [3:0]                     cur_digit;
   logic [6:0]                     seg_next;
   logic [6:0]                     seg_q;
   logic [numberOfDigits-1:0]      sel_q;
   logic                           frame_q;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'h40;
         4'd1:    decode = 7'h79;
         4'd2:    decode = 7'h24;
         4'd3:    decode = 7'h30;
         4'd4:    decode = 7'h19;
         4'd5:    decode = 7'h12;
         4'd6:    decode = 7'h02;
         4'd7:    decode = 7'h78;
         4'd8:    decode = 7'h00;
         4'd9:    decode = 7'h10;
         default: decode = 7'h3F;
      endcase
   endfunction

   assign tick = (count == count_last);
   assign wrap = tick && (index == index_last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count        <= '0;
         index        <= '0;
         pending      <= '0;
         display      <= '0;
         pending_flag <= 1'b0;
         wrap_q       <= 1'b0;
      end else begin
         count  <= tick ? '0 : count + CW'(1);
         wrap_q <= wrap;
         if (tick)
            index <= wrap ? '0 : index + IW'(1);
         if (wrap && pending_flag) begin
            display      <= pending;
            pending_flag <= 1'b0;
         end
         // A new strobe on the transfer edge re-arms the flag with the fresh value.
         if (bus.enaIn) begin
            pending      <= bus.BinaryDecimal;
            pending_flag <= 1'b1;
         end
      end
   end

`ifdef BCD_LZ_BLANK_EN
   logic [IW-1:0] msd;

   always_comb begin
      msd = '0;
      for (int i = 1; i < numberOfDigits; i++)
         if (display[i] != 4'd0)
            msd = IW'(i);
   end

   assign blank = (index > msd);
`else
   assign blank = 1'b0;
`endif

   always_comb begin
      cur_digit = display[index];
      seg_next  = blank ? 7'h7F : decode(cur_digit);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_q   <= 7'h7F;
         sel_q   <= '1;
         frame_q <= 1'b0;
      end else begin
         seg_q   <= seg_next;
         sel_q   <= ~(one_hot0 << index);
         frame_q <= wrap_q;
      end
   end

   assign bus.segments   = seg_q;
   assign bus.digitSel   = sel_q;
   assign bus.frameStart = frame_q;
endmodule

// File: doc/bcd_seg_scan.md
BCD_SEG_SCAN -- requirements
Module: bcd_seg_scan

Interface
REQ-001 Parameter numberOfDigits, default 6: number of BCD digits accepted and scanned; legal range 1..8.
REQ-002 Parameter refreshDivider, default 50000: clk cycles per digit slot; legal range >=2.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 BinaryDecimal  input  [numberOfDigits-1:0][3:0]  packed BCD value from the upstream binary-to-BCD converter; digit 0 is least significant.
REQ-006 enaIn  input  1  single-cycle valid strobe from upstream (its enaOut); BinaryDecimal is sampled only when high.
REQ-007 segments  output  7  active-low segment drive {g,f,e,d,c,b,a}.
REQ-008 digitSel  output  numberOfDigits  active-low one-hot digit enable.
REQ-009 frameStart  output  1  one-cycle pulse when the scan index wraps to digit 0.

Function
REQ-010 Prescaler SHALL count 0..refreshDivider-1 and wrap; tick = (count == refreshDivider-1).
REQ-011 On tick, scan index SHALL advance by 1, wrapping numberOfDigits-1 -> 0; no change otherwise.
REQ-012 When enaIn=1, BinaryDecimal SHALL be stored in a pending register and the pending flag set.
REQ-013 On a tick that wraps the index to 0 with pending flag set, the pending register SHALL be copied to the display register and the flag cleared; the display register SHALL change at no other time (no mid-frame tearing).
REQ-014 enaIn on the same edge as a wrap transfer: display SHALL take the old pending value, pending SHALL take the new value, flag SHALL remain set.
REQ-015 Repeated enaIn before a wrap: last value SHALL win; earlier values are dropped without error.
REQ-016 segments and digitSel SHALL be registered, reflecting scan index and display register with exactly 1 clk latency.
REQ-017 digitSel SHALL drive low exactly the bit of the current index; all other bits high.
REQ-018 Decode (hex, active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10.
REQ-019 Digit codes 10..15 SHALL display a dash, segments=3F.
REQ-020 frameStart SHALL pulse high for one cycle, on the edge after the wrap tick, aligned with digitSel selecting digit 0.

Reset
REQ-021 While rst=1: prescaler=0, index=0, pending=0, flag=0, display=0, segments=7F, digitSel all ones, frameStart=0.
REQ-022 rst asserted mid-frame or mid-transfer SHALL abort immediately; the pending value is lost.
REQ-023 After rst release, the first tick SHALL occur refreshDivider cycles later; outputs SHALL show digit 0 of display (0 -> 40) from the first edge after release.

Configuration
REQ-024 Macro BCD_LZ_BLANK_EN defined: digits above the most significant nonzero digit of the display register SHALL be blanked (segments=7F, digitSel still scans); digit 0 never blanked; dash digits count as nonzero.
REQ-025 BCD_LZ_BLANK_EN undefined: every digit SHALL be decoded and shown, including leading zeros.

Verification (numberOfDigits=6, refreshDivider=4)
REQ-026 Reset then idle 30 cycles -> digitSel steps 3E,3D,3B,37,2F,1F every 4 cycles; segments=40 every slot; frameStart once per 24 cycles.
REQ-027 enaIn with 000123 mid-frame -> display unchanged until next frameStart; following frame digits 0..2 show 30,24,79; digits 3..5 show 40 (macro off) or 7F (macro on).
REQ-028 enaIn with 000111 then 000999 within one frame -> next frame shows 999 only; 111 never displayed.
REQ-029 enaIn with 00000A on the wrap-tick edge -> that frame shows prior pending value; next frame digit 0 shows 3F.
REQ-030 rst pulsed for 1 cycle mid-slot with pending 654321 -> outputs immediately 7F / all ones; after release display shows 000000, pending lost.
REQ-031 Macro on, value 000000 -> digit 0 shows 40, digits 1..5 show 7F.
